// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/shift/add ops plus iterative MUL/MULHU/DIVU/REMU.
// Results and flags are registered and held in DONE until the consumer takes them.
module alu_seq #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal,
  output logic         busy
);
  localparam int unsigned SH = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR  = 4'd2,  OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,  OP_SRA  = 4'd5,  OP_ADD  = 4'd6,  OP_SUB  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_MULHU = 4'd11,
    OP_DIVU = 4'd12, OP_REMU = 4'd13
  } op_e;

  state_e         state_q, state_d;
  logic [SH-1:0]  cnt_q, cnt_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d, zero_q, zero_d, equal_q, equal_d;

  // Single-cycle datapath
  logic [N-1:0]  sum, diff, sra_res, sc_res;
  logic [SH-1:0] shamt;
  logic          ovf_add, ovf_sub, shift_big, sc_ovf;

  assign sra_res = $signed(a) >>> shamt;

  always_comb begin
    sum       = a + b;
    diff      = a - b;
    ovf_add   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
    ovf_sub   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
    shamt     = b[SH-1:0];
    shift_big = |b[N-1:SH];
    sc_res    = '0;
    sc_ovf    = 1'b0;
    case (op)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLL:  sc_res = shift_big ? '0 : (a << shamt);
      OP_SRL:  sc_res = shift_big ? '0 : (a >> shamt);
      OP_SRA:  sc_res = shift_big ? {N{a[N-1]}} : sra_res;
      OP_ADD:  begin sc_res = sum;  sc_ovf = ovf_add; end
      OP_SUB:  begin sc_res = diff; sc_ovf = ovf_sub; end
      OP_SLT:  begin sc_res = {{(N-1){1'b0}}, diff[N-1] ^ ovf_sub}; sc_ovf = ovf_sub; end
      OP_SLTU: sc_res = {{(N-1){1'b0}}, a < b};
      default: sc_res = '0;
    endcase
  end

  // Iterative step: acc = {hi, lo}. MUL: hi = partial sum, lo = multiplier shifting out.
  // DIVU: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
  logic [N:0]     mul_sum, div_shift;
  logic [N-1:0]   div_sub, div_rem;
  logic           div_ge, is_mul_q, is_mul_in, is_iter_in;
  logic [2*N-1:0] iter_next;

  always_comb begin
    is_mul_q   = (op_q == OP_MUL) || (op_q == OP_MULHU);
    is_mul_in  = (op == OP_MUL) || (op == OP_MULHU);
    is_iter_in = (op >= OP_MUL) && (op <= OP_REMU);
    mul_sum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_shift  = {acc_q[2*N-1:N], acc_q[N-1]};
    div_ge     = div_shift >= {1'b0, b_q};
    div_sub    = div_shift[N-1:0] - b_q;
    div_rem    = div_ge ? div_sub : div_shift[N-1:0];
    iter_next  = is_mul_q ? {mul_sum, acc_q[N-1:1]} : {div_rem, acc_q[N-2:0], div_ge};
  end

  assign i_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & o_ready));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    equal_d  = equal_q;
    case (state_q)
      S_BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q - SH'(1);
        if (cnt_q == '0) begin
          // op_q[0] selects the high half: MULHU product high, REMU remainder.
          result_d = op_q[0] ? iter_next[2*N-1:N] : iter_next[N-1:0];
          ovf_d    = (op_q == OP_MUL) && (|iter_next[2*N-1:N]);
          zero_d   = (op_q[0] ? iter_next[2*N-1:N] : iter_next[N-1:0]) == '0;
          equal_d  = (a_q == b_q);
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  if (o_ready) state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    if (i_valid && i_ready) begin
      op_d = op;
      a_d  = a;
      b_d  = b;
      if (is_iter_in) begin
        state_d = S_BUSY;
        cnt_d   = SH'(N - 1);
        acc_d   = is_mul_in ? {{N{1'b0}}, b} : {{N{1'b0}}, a};
      end else begin
        state_d  = S_DONE;
        result_d = sc_res;
        ovf_d    = sc_ovf;
        zero_d   = (sc_res == '0);
        equal_d  = (a == b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      equal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      equal_q  <= equal_d;
    end
  end

  assign o_valid  = (state_q == S_DONE);
  assign busy     = (state_q == S_BUSY);
  assign result   = result_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign equal    = equal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: expected results queued at issue time, compared when o_valid shows.
module tb_alu_seq;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst, i_valid, o_ready;
  logic         i_ready, o_valid, overflow, zero, equal, busy;
  logic [3:0]   op;
  logic [N-1:0] a, b, result;
  logic [N+2:0] got;

  typedef struct packed {
    logic [N-1:0] res;
    logic         ovf;
    logic         zero;
    logic         eq;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  alu_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .op(op), .a(a), .b(b),
    .o_valid(o_valid), .o_ready(o_ready), .result(result), .overflow(overflow),
    .zero(zero), .equal(equal), .busy(busy)
  );

  always #5 clk = ~clk;
  assign got = {result, overflow, zero, equal};

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [N-1:0] r, input logic v, input logic z, input logic q);
    mk = '{res: r, ovf: v, zero: z, eq: q};
  endfunction

  // Reference model built from plain arithmetic operators.
  function automatic exp_t model(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t          e;
    longint        sx, sy, r;
    logic [63:0]   p;
    logic signed [N-1:0] t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    case (o)
      4'd0: e.res = x & y;
      4'd1: e.res = x | y;
      4'd2: e.res = x ^ y;
      4'd3: e.res = (y >= N) ? '0 : x << y[4:0];
      4'd4: e.res = (y >= N) ? '0 : x >> y[4:0];
      4'd5: begin t = $signed(x) >>> y[4:0]; e.res = (y >= N) ? {N{x[N-1]}} : t; end
      4'd6: begin r = sx + sy; e.res = x + y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd7: begin r = sx - sy; e.res = x - y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd8: begin r = sx - sy; e.res = (sx < sy) ? 1 : 0; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'd9: e.res = (x < y) ? 1 : 0;
      4'd10: begin p = {32'b0, x} * {32'b0, y}; e.res = p[31:0]; e.ovf = |p[63:32]; end
      4'd11: begin p = {32'b0, x} * {32'b0, y}; e.res = p[63:32]; end
      4'd12: e.res = (y == 0) ? '1 : x / y;
      4'd13: e.res = (y == 0) ? x : x % y;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    e.eq   = (x == y);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one op for one edge (assumes i_ready) and scrambles operands afterwards.
  task automatic issue(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input exp_t e);
    op = o; a = x; b = y; i_valid = 1'b1;
    sb_q.push_back(e);
    step();
    i_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_out(output int cyc, output int bc, output bit to);
    cyc = 0; bc = 0;
    while (o_valid !== 1'b1 && cyc < 4 * N) begin
      if (busy === 1'b1) bc++;
      step();
      cyc++;
    end
    to = (o_valid !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; op = '0; a = '0; b = '0;
    step(); step();
    tests++;
    if ({o_valid, busy, i_ready} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl got {o_valid,busy,i_ready}=%b required 000", {o_valid, busy, i_ready});
    end
    tests++;
    if (got !== '0) begin
      fails++; $display("FAIL reset_data got %h required 0", got);
    end
    rst = 1'b0; #1;
    tests++;
    if (i_ready !== 1'b1) begin
      fails++; $display("FAIL reset_iready got %b required 1", i_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0]   ops[10]  = '{4'd6, 4'd7, 4'd3, 4'd5, 4'd4, 4'd8, 4'd9, 4'd7, 4'd14, 4'd8};
    logic [N-1:0] av[10]   = '{32'h7FFFFFFF, 32'h1234, 32'h1, 32'h80000000, 32'h80000000,
                               32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h5, 32'h80000000};
    logic [N-1:0] bv[10]   = '{32'h1, 32'h1234, 32'd32, 32'd33, 32'd31, 32'h1, 32'h1, 32'h1, 32'h5, 32'h1};
    exp_t         ev[10];
    exp_t         e;
    int           cyc, bc;
    bit           to;
    ev = '{mk(32'h80000000, 1, 0, 0), mk(32'h0, 0, 1, 1), mk(32'h0, 0, 1, 0), mk(32'hFFFFFFFF, 0, 0, 0),
           mk(32'h1, 0, 0, 0), mk(32'h1, 0, 0, 0), mk(32'h0, 0, 1, 0), mk(32'h7FFFFFFF, 1, 0, 0),
           mk(32'h0, 0, 1, 1), mk(32'h1, 1, 0, 0)};
    o_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], av[i], bv[i], ev[i]);
      wait_out(cyc, bc, to);
      tests++;
      if (to || cyc != 0) begin
        fails++; $display("FAIL single_latency[%0d] got %0d extra cycles required 0", i, cyc);
      end
      e = sb_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL single_result[%0d] op=%0d got %h required %h", i, ops[i], got, e);
      end
    end
    step();
  endtask

  task automatic test_iterative();
    logic [3:0]   ops[6] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
    logic [N-1:0] av[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [N-1:0] bv[6]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0};
    exp_t         ev[6];
    exp_t         e;
    int           cyc, bc;
    bit           to;
    ev = '{mk(32'hFFFFFFFE, 1, 0, 0), mk(32'h1, 0, 0, 0), mk(32'd14, 0, 0, 0),
           mk(32'd2, 0, 0, 0), mk(32'hFFFFFFFF, 0, 0, 0), mk(32'd5, 0, 0, 0)};
    o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i], ev[i]);
      wait_out(cyc, bc, to);
      tests++;
      if (to || cyc != N || bc != N) begin
        fails++; $display("FAIL iter_latency[%0d] got cycles=%0d busy=%0d required %0d", i, cyc, bc, N);
      end
      e = sb_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL iter_result[%0d] op=%0d got %h required %h", i, ops[i], got, e);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   o;
    logic [N-1:0] x, y;
    exp_t         e;
    int           cyc, bc;
    bit           to;
    o_ready = 1'b1;
    o = 4'($urandom_range(0, 9)); x = $urandom; y = $urandom_range(0, 40);
    op = o; a = x; b = y; i_valid = 1'b1;
    sb_q.push_back(model(o, x, y));
    step();
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if (o_valid !== 1'b1 || i_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_handshake[%0d] got o_valid=%b i_ready=%b required 1 1", i, o_valid, i_ready);
      end
      e = sb_q.pop_front();
      tests++;
      if (got !== e) begin
        fails++; $display("FAIL b2b_result[%0d] got %h required %h", i, got, e);
      end
      if (i < 8) begin
        o = 4'($urandom_range(0, 9)); x = $urandom; y = $urandom_range(0, 40);
        op = o; a = x; b = y;
        sb_q.push_back(model(o, x, y));
      end else begin
        i_valid = 1'b0;
      end
      step();
    end
    tests++;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got o_valid=%b required 0", o_valid);
    end
    // Iterative pair: second accept happens in the DONE cycle of the first.
    x = $urandom; y = $urandom_range(1, 1000);
    issue(4'd12, x, y, model(4'd12, x, y));
    wait_out(cyc, bc, to);
    e = sb_q.pop_front();
    tests++;
    if (to || got !== e || i_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_iter_first got %h i_ready=%b required %h 1", got, i_ready, e);
    end
    x = $urandom; y = $urandom;
    issue(4'd11, x, y, model(4'd11, x, y));
    wait_out(cyc, bc, to);
    tests++;
    if (to || cyc != N) begin
      fails++; $display("FAIL b2b_iter_gap got %0d cycles required %0d", cyc + 1, N + 1);
    end
    e = sb_q.pop_front();
    tests++;
    if (got !== e) begin
      fails++; $display("FAIL b2b_iter_second got %h required %h", got, e);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [N+2:0] held;
    exp_t         e;
    o_ready = 1'b0;
    issue(4'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, mk(32'hAAAAAAAA, 0, 0, 0));
    held = got;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (o_valid !== 1'b1 || got !== held || i_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got o_valid=%b data=%h i_ready=%b required 1 %h 0",
                          i, o_valid, got, i_ready, held);
      end
      step();
    end
    e = sb_q.pop_front();
    tests++;
    if (got !== e) begin
      fails++; $display("FAIL bp_result got %h required %h", got, e);
    end
    o_ready = 1'b1; i_valid = 1'b1; op = 4'd0; a = 32'hF0; b = 32'h3C;
    sb_q.push_back(mk(32'h30, 0, 0, 0));
    #1;
    tests++;
    if (i_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release_iready got %b required 1", i_ready);
    end
    step();
    i_valid = 1'b0;
    e = sb_q.pop_front();
    tests++;
    if (o_valid !== 1'b1 || got !== e) begin
      fails++; $display("FAIL bp_and got o_valid=%b data=%h required 1 %h", o_valid, got, e);
    end
    step();
    tests++;
    if (o_valid !== 1'b0) begin
      fails++; $display("FAIL bp_no_duplicate got o_valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc, bc;
    bit   to;
    o_ready = 1'b1;
    issue(4'd12, 32'd1000, 32'd3, model(4'd12, 32'd1000, 32'd3));
    repeat (9) step();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_busy got %b required 1", busy);
    end
    rst = 1'b1;
    step();
    void'(sb_q.pop_back());
    tests++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort got o_valid=%b busy=%b required 0 0", o_valid, busy);
    end
    rst = 1'b0; #1;
    tests++;
    if (i_ready !== 1'b1) begin
      fails++; $display("FAIL rstmid_iready got %b required 1", i_ready);
    end
    issue(4'd6, 32'd2, 32'd3, mk(32'd5, 0, 0, 0));
    wait_out(cyc, bc, to);
    e = sb_q.pop_front();
    tests++;
    if (to || cyc != 0 || got !== e) begin
      fails++; $display("FAIL rstmid_add got %h after %0d cycles required %h after 0", got, cyc, e);
    end
    step();
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [N-1:0] x, y;
    exp_t         e;
    int           cyc, bc, want;
    bit           to;
    o_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = $urandom_range(0, 40);
        2: y = '0;
        default: y = x;
      endcase
      want = (o >= 4'd10 && o <= 4'd13) ? N : 0;
      issue(o, x, y, model(o, x, y));
      wait_out(cyc, bc, to);
      e = sb_q.pop_front();
      tests++;
      if (to || cyc != want || got !== e) begin
        fails++; $display("FAIL random[%0d] op=%0d a=%h b=%h got %h after %0d required %h after %0d",
                          i, o, x, y, got, cyc, e, want);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_iterative();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
